key_debounce: RTL

//  Conditions raw push-button inputs before they reach the key PIO's in_port.
//  Per key: two-flop synchronizer, then a stability counter that accepts a new level only after
//  it holds for DEBOUNCE_CYCLES consecutive clocks. Outputs the debounced level at raw polarity
//  (drop-in for in_port) plus one-cycle press/release pulses for NIOS-independent logic.

---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/key_debounce_chan.sv | 74 +++++++
 rtl/key_debounce.sv | 32 +++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// Shared defaults and polarity helpers for the push-button debouncer.
package key_debounce_pkg;

  localparam int unsigned KEY_DEBOUNCE_DEFAULT   = 32'd500000;
  localparam bit          KEY_ACTIVE_LOW_DEFAULT = 1'b1;

  function automatic logic released_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  function automatic logic pressed_level(input bit active_low);
    return active_low ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: two-flop synchronizer, stability counter, registered
// press/release pulses. The level only moves after DEBOUNCE_CYCLES stable clocks.
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter bit          ACTIVE_LOW      = KEY_ACTIVE_LOW_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 32'd2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic LVL_RELEASED = released_level(ACTIVE_LOW);
  localparam logic LVL_PRESSED  = pressed_level(ACTIVE_LOW);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // State registers; reset forces the released level and drops any pending change.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q      <= LVL_RELEASED;
      s2_q      <= LVL_RELEASED;
      level_q   <= LVL_RELEASED;
      cnt_q     <= CNT_ZERO;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Synchronizer shift, stability count and level acceptance.
  always_comb begin
    s1_d      = raw;
    s2_d      = s1_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      level_d   = s2_q;
      cnt_d     = CNT_ZERO;
      press_d   = (s2_q == LVL_PRESSED);
      release_d = (s2_q == LVL_RELEASED);
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces N_KEYS raw push-buttons; key_level keeps raw polarity so it can
// feed a PIO in_port directly, with one-clock press/release pulses alongside.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS          = 32'd2,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter bit          ACTIVE_LOW      = KEY_ACTIVE_LOW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw       (key_raw[g]),
      .level     (key_level[g]),
      .press     (key_press[g]),
      .release_o (key_release[g])
    );
  end

endmodule
